// File: rtl/aclk_core.sv
// Alarm clock core: 24 h BCD time-of-day counter with a prescaler on the
// input clock, loadable time and alarm registers, and a registered alarm flag.
module aclk_core #(
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       LD_time,
  input  logic       LD_alarm,
  input  logic       STOP_al,
  input  logic       AL_ON,
  output logic       Alarm,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] S_out1,
  output logic [3:0] S_out0
);

  localparam int unsigned PreW = $clog2(TICKS_PER_SEC);
  localparam logic [PreW-1:0] PreMax = PreW'(TICKS_PER_SEC - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic [1:0] h1_q, h1_d;
  logic [3:0] h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;
  logic [1:0] al_h1_q, al_h1_d;
  logic [3:0] al_h0_q, al_h0_d, al_m1_q, al_m1_d, al_m0_q, al_m0_d;
  logic       alarm_q, alarm_d;

  logic tick, in_valid, upd, match;

  assign tick = (pre_q == PreMax);

  // Hours above 23 are rejected, so H_in1 == 2 limits the units digit to 3.
  assign in_valid = (H_in1 <= 2'd2) && (H_in0 <= 4'd9) && (M_in1 <= 4'd5) &&
                    (M_in0 <= 4'd9) && !((H_in1 == 2'd2) && (H_in0 > 4'd3));

  // Next time-of-day: a valid load wins over the one-second tick.
  always_comb begin
    pre_d = pre_q + PreW'(1);
    h1_d  = h1_q;
    h0_d  = h0_q;
    m1_d  = m1_q;
    m0_d  = m0_q;
    s1_d  = s1_q;
    s0_d  = s0_q;
    upd   = 1'b0;
    if (LD_time && in_valid) begin
      upd   = 1'b1;
      pre_d = '0;
      h1_d  = H_in1;
      h0_d  = H_in0;
      m1_d  = M_in1;
      m0_d  = M_in0;
      s1_d  = 4'd0;
      s0_d  = 4'd0;
    end else if (tick) begin
      upd   = 1'b1;
      pre_d = '0;
      if (s0_q == 4'd9) begin
        s0_d = 4'd0;
        if (s1_q == 4'd5) begin
          s1_d = 4'd0;
          if (m0_q == 4'd9) begin
            m0_d = 4'd0;
            if (m1_q == 4'd5) begin
              m1_d = 4'd0;
              if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                h1_d = 2'd0;
                h0_d = 4'd0;
              end else if (h0_q == 4'd9) begin
                h0_d = 4'd0;
                h1_d = h1_q + 2'd1;
              end else begin
                h0_d = h0_q + 4'd1;
              end
            end else begin
              m1_d = m1_q + 4'd1;
            end
          end else begin
            m0_d = m0_q + 4'd1;
          end
        end else begin
          s1_d = s1_q + 4'd1;
        end
      end else begin
        s0_d = s0_q + 4'd1;
      end
    end
  end

  // Alarm value and flag; the match uses next-state time against the current alarm.
  always_comb begin
    al_h1_d = al_h1_q;
    al_h0_d = al_h0_q;
    al_m1_d = al_m1_q;
    al_m0_d = al_m0_q;
    if (LD_alarm && in_valid) begin
      al_h1_d = H_in1;
      al_h0_d = H_in0;
      al_m1_d = M_in1;
      al_m0_d = M_in0;
    end
    match = upd && (h1_d == al_h1_q) && (h0_d == al_h0_q) && (m1_d == al_m1_q) &&
            (m0_d == al_m0_q) && (s1_d == 4'd0) && (s0_d == 4'd0);
    alarm_d = alarm_q;
    if (STOP_al || !AL_ON) begin
      alarm_d = 1'b0;
    end else if (match) begin
      alarm_d = 1'b1;
    end
  end

  // State registers; either reset input clears everything and masks loads.
  always_ff @(posedge clk) begin
    if (!reset_n || reset) begin
      pre_q   <= '0;
      h1_q    <= 2'd0;
      h0_q    <= 4'd0;
      m1_q    <= 4'd0;
      m0_q    <= 4'd0;
      s1_q    <= 4'd0;
      s0_q    <= 4'd0;
      al_h1_q <= 2'd0;
      al_h0_q <= 4'd0;
      al_m1_q <= 4'd0;
      al_m0_q <= 4'd0;
      alarm_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      al_h1_q <= al_h1_d;
      al_h0_q <= al_h0_d;
      al_m1_q <= al_m1_d;
      al_m0_q <= al_m0_d;
      alarm_q <= alarm_d;
    end
  end

  assign Alarm  = alarm_q;
  assign H_out1 = h1_q;
  assign H_out0 = h0_q;
  assign M_out1 = m1_q;
  assign M_out0 = m0_q;
  assign S_out1 = s1_q;
  assign S_out0 = s0_q;

endmodule

// File: tb/tb_aclk_core.sv
// Bench for aclk_core: seconds-of-day model checked every cycle, plus literal checkpoints.
module tb_aclk_core;

  localparam int T = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, reset, ld_time, ld_alarm, stop_al, al_on;
  logic [1:0] h_in1;
  logic [3:0] h_in0, m_in1, m_in0;
  logic       alarm;
  logic [1:0] h_out1;
  logic [3:0] h_out0, m_out1, m_out0, s_out1, s_out0;

  aclk_core #(.TICKS_PER_SEC(T)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reset    (reset),
    .H_in1    (h_in1),
    .H_in0    (h_in0),
    .M_in1    (m_in1),
    .M_in0    (m_in0),
    .LD_time  (ld_time),
    .LD_alarm (ld_alarm),
    .STOP_al  (stop_al),
    .AL_ON    (al_on),
    .Alarm    (alarm),
    .H_out1   (h_out1),
    .H_out0   (h_out0),
    .M_out1   (m_out1),
    .M_out0   (m_out0),
    .S_out1   (s_out1),
    .S_out0   (s_out0)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: time as seconds of day, alarm as minutes of day.
  int m_tod = 0;
  int m_pre = 0;
  int m_al  = 0;
  bit m_flag = 1'b0;

  logic [22:0] dut_vec;
  assign dut_vec = {alarm, h_out1, h_out0, m_out1, m_out0, s_out1, s_out0};

  function automatic logic [22:0] pack(bit a, int tod);
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    return {a, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_step();
    int  hh, mm, ntod, npre;
    bit  v, upd, match;
    if (!reset_n || reset) begin
      m_tod = 0; m_pre = 0; m_al = 0; m_flag = 1'b0;
      return;
    end
    hh = int'(h_in1) * 10 + int'(h_in0);
    mm = int'(m_in1) * 10 + int'(m_in0);
    v = (h_in0 <= 9) && (m_in1 <= 5) && (m_in0 <= 9) && (hh < 24);
    upd = 1'b0;
    ntod = m_tod;
    if (ld_time && v) begin
      ntod = hh * 3600 + mm * 60; npre = 0; upd = 1'b1;
    end else if (m_pre == T - 1) begin
      ntod = (m_tod + 1) % 86400; npre = 0; upd = 1'b1;
    end else begin
      npre = m_pre + 1;
    end
    match = upd && (ntod == m_al * 60);
    if (stop_al || !al_on) m_flag = 1'b0;
    else if (match) m_flag = 1'b1;
    if (ld_alarm && v) m_al = hh * 60 + mm;
    m_tod = ntod;
    m_pre = npre;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (dut_vec !== pack(m_flag, m_tod)) begin
        fails++;
        $display("FAIL model_compare t=%0t got %h required %h", $time, dut_vec,
                 pack(m_flag, m_tod));
      end
    end
  end

  task automatic check(string name, int hh, int mm, int ss, bit a);
    logic [22:0] exp;
    exp = pack(a, hh * 3600 + mm * 60 + ss);
    tests++;
    if (dut_vec !== exp) begin
      fails++;
      $display("FAIL %s got %h required %h", name, dut_vec, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic set_in(int hh, int mm);
    h_in1 = 2'(hh / 10);
    h_in0 = 4'(hh % 10);
    m_in1 = 4'(mm / 10);
    m_in0 = 4'(mm % 10);
  endtask

  task automatic load_time(int hh, int mm);
    set_in(hh, mm);
    ld_time = 1'b1;
    step(1);
    ld_time = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; reset = 1'b0; ld_time = 1'b0; ld_alarm = 1'b0;
    stop_al = 1'b0; al_on = 1'b0;
    set_in(0, 0);

    // Power-on reset and free run.
    step(1);
    chk_en = 1'b1;
    step(1);
    check("reset_state", 0, 0, 0, 0);
    reset_n = 1'b1;
    step(9);
    check("before_first_tick", 0, 0, 0, 0);
    step(1);
    check("first_second", 0, 0, 1, 0);
    step(90);
    check("ten_seconds", 0, 0, 10, 0);

    // Midnight rollover.
    load_time(23, 59);
    check("load_2359", 23, 59, 0, 0);
    step(590);
    check("at_235959", 23, 59, 59, 0);
    step(10);
    check("midnight_wrap", 0, 0, 0, 0);

    // Alarm rises with 07:30:00 and holds until STOP.
    al_on = 1'b1;
    set_in(7, 30);
    ld_alarm = 1'b1;
    step(1);
    ld_alarm = 1'b0;
    load_time(7, 29);
    check("load_0729", 7, 29, 0, 0);
    step(599);
    check("pre_match", 7, 29, 59, 0);
    step(1);
    check("match_edge", 7, 30, 0, 1);
    step(20);
    check("alarm_holds", 7, 30, 2, 1);
    stop_al = 1'b1;
    step(1);
    check("stop_clears", 7, 30, 2, 0);
    stop_al = 1'b0;
    step(15);
    check("no_reassert", 7, 30, 3, 0);

    // STOP on the match cycle itself wins.
    load_time(7, 29);
    step(599);
    stop_al = 1'b1;
    step(1);
    check("stop_on_match", 7, 30, 0, 0);
    stop_al = 1'b0;
    step(20);
    check("stop_on_match_after", 7, 30, 2, 0);

    // AL_ON low suppresses the match.
    al_on = 1'b0;
    load_time(7, 29);
    step(600);
    check("al_on_off", 7, 30, 0, 0);

    // AL_ON falling clears a ringing alarm.
    al_on = 1'b1;
    load_time(7, 29);
    step(600);
    check("ring_again", 7, 30, 0, 1);
    al_on = 1'b0;
    step(1);
    check("al_on_fall", 7, 30, 0, 0);
    al_on = 1'b1;

    // Invalid 25:00 load is ignored, clock keeps counting.
    load_time(10, 15);
    step(25);
    check("before_invalid", 10, 15, 2, 0);
    h_in1 = 2'd2; h_in0 = 4'd5; m_in1 = 4'd0; m_in0 = 4'd0;
    ld_time = 1'b1;
    step(1);
    ld_time = 1'b0;
    check("invalid_ignored", 10, 15, 2, 0);
    step(4);
    check("invalid_keeps_running", 10, 15, 3, 0);

    // Simultaneous time and alarm load.
    set_in(12, 0);
    ld_time = 1'b1;
    ld_alarm = 1'b1;
    step(1);
    ld_time = 1'b0;
    ld_alarm = 1'b0;
    check("dual_load", 12, 0, 0, 0);
    load_time(11, 59);
    step(600);
    check("dual_load_alarm", 12, 0, 0, 1);

    // reset clears a ringing alarm, time and alarm setting.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("reset_pulse", 0, 0, 0, 0);
    load_time(23, 59);
    step(600);
    check("alarm_reg_cleared", 0, 0, 0, 1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aclk_core.md
# aclk_core

Alarm clock core that answers the stimulus side of the `aclk_if` bench interface. It consumes the `reset`/load/alarm-control inputs and produces the BCD time digits and the `Alarm` output. A prescaler on the nominal 10 Hz `clk` keeps real-time seconds. A time-of-day counter runs in 24 h BCD, and a registered alarm comparator sets `Alarm`. The block sits directly behind the interface as the DUT the bench drives and monitors.

## Interface
- `TICKS_PER_SEC`, default 10: `clk` cycles per second. Must be ≥2.
- `clk` input 1: 10 Hz clock. All logic is on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `reset` input 1: synchronous active-high clear of time and alarm to 00:00:00.
- `H_in1` input 2: hour tens digit to load.
- `H_in0` input 4: hour units digit to load.
- `M_in1` input 4: minute tens digit to load.
- `M_in0` input 4: minute units digit to load.
- `LD_time` input 1: load the time from the inputs.
- `LD_alarm` input 1: load the alarm from the inputs.
- `STOP_al` input 1: clear `Alarm`.
- `AL_ON` input 1: enables the alarm function.
- `Alarm` output 1: high while the alarm is ringing.
- `H_out1` output 2: hour tens digit.
- `H_out0` output 4: hour units digit.
- `M_out1` output 4: minute tens digit.
- `M_out0` output 4: minute units digit.
- `S_out1` output 4: second tens digit.
- `S_out0` output 4: second units digit.

## Operation
- **State**
  - Prescaler `pre` counts 0..TICKS_PER_SEC-1.
  - Time registers are six BCD digits.
  - Alarm registers hold hour and minute digits; alarm seconds are fixed at 00.
  - `Alarm` is a flag register.
- **Reset.** With `reset_n`=0, or with `reset`=1 while `reset_n`=1:
  - `pre`, all time digits, all alarm digits and `Alarm` go to 0.
  - All loads and ticks in that cycle are ignored.
- **Tick.** `tick` = (`pre` == TICKS_PER_SEC-1).
  - `pre` wraps to 0 on `tick`, otherwise increments.
  - On `tick`, the time advances by 1 s with BCD carries:
    - S0 9→0 carries into S1.
    - S1 5→0 carries into M0.
    - M0 9→0 carries into M1.
    - M1 5→0 carries into hours.
    - Hours 23→00 when the time is 23:59:59.
    - H0 rolls over 9→0 only while H1<2.
- **Valid input.** Valid when H_in1≤2, H_in0≤9, M_in1≤5, M_in0≤9, and H_in0≤3 if H_in1=2.
- **LD_time** with valid input:
  - Hours and minutes take the input values.
  - Seconds and `pre` go to 0.
  - Takes priority over `tick` in the same cycle.
  - With invalid input, LD_time is ignored and the clock keeps running normally.
- **LD_alarm** with valid input loads the alarm hours and minutes. Invalid input is ignored.
  - LD_alarm does not affect `Alarm`.
  - LD_time and LD_alarm together load both from the same inputs.
- **Match event.** Occurs in a cycle in which the time registers are updated (by `tick` or LD_time) to exactly alarm HH:MM:00.
  - Comparison uses the next-state time against the alarm value current in that cycle.
  - Reset never generates a match.
- **Alarm next-state priority**, highest first:
  1. Reset → 0.
  2. STOP_al=1 or AL_ON=0 → 0.
  3. Match event → 1.
  4. Otherwise hold.
- `Alarm` stays high until STOP_al, AL_ON falling, or reset. Time keeps running while it is high.

## Timing
- All outputs are registered. Reset value of every output is 0.
- After reset is released at edge E0, S_out0 becomes 1 at edge E0+TICKS_PER_SEC, then increments every TICKS_PER_SEC edges.
- LD_time sampled at edge E:
  - Outputs show HH:MM:00 after E.
  - The first increment to :01 follows at E+TICKS_PER_SEC.
- `Alarm` rises on the same edge at which the outputs first show the matching HH:MM:00. There is zero cycles of lag relative to the displayed time.
- STOP_al or AL_ON=0 sampled at edge E drives `Alarm` low after E, even if a match event occurs at E.
- After STOP, `Alarm` does not re-assert during the remaining cycles of that second. It re-asserts only at the next match event, 24 h later or after a reload.

## Test plan
- Pulse reset_n=0 for 2 cycles, then release.
  - Required: all outputs are 0.
  - Required: S_out0=1 after exactly 10 clocks and S_out1:S_out0=10 after 100 clocks.
- Apply LD_time with 23:59, then run 600 clocks.
  - Required: 23:59:59 at clock 590.
  - Required: 00:00:00 at clock 600 with all digits wrapped.
- Apply LD_alarm 07:30, AL_ON=1, then LD_time 07:29 and run 600 clocks.
  - Required: `Alarm` rises exactly on the clock at which the outputs show 07:30:00.
  - Required: `Alarm` stays high until STOP_al=1, and is low on the next clock.
- Repeat the match setup and assert STOP_al=1 on the match cycle.
  - Required: `Alarm` stays 0 throughout.
- Repeat the match setup with AL_ON=0.
  - Required: `Alarm` stays 0.
- Apply LD_time with H_in1=2, H_in0=5 (25:00).
  - Required: the load is ignored and the time continues from its prior value.
- Apply LD_time and LD_alarm together with 12:00.
  - Required: both are loaded.
  - Required: no `Alarm` on that cycle.
- Pulse reset=1 while `Alarm` is high.
  - Required: time, alarm and `Alarm` all read 0 on the next clock.
